// File: rtl/sync_fifo.sv
`default_nettype none
// ============================================================================
// Module   : sync_fifo
// Brief    : Single-clock FIFO with standard or FWFT read, almost flags,
//            synchronous flush and sticky overflow/underflow flags.
//            Optional peak-level port enabled by SYNC_FIFO_WATERMARK_EN.
// Revision : 1.0
// ============================================================================
module sync_fifo #(
   parameter int WIDTH         = 8,
   parameter int DEPTH         = 16,
   parameter int AFULL_THRESH  = DEPTH - 2,
   parameter int AEMPTY_THRESH = 2,
   parameter int FWFT          = 0
) (
   input  logic                     i_clk,
   input  logic                     i_rst_n,
   input  logic                     flush,
   input  logic                     wr_en,
   input  logic [WIDTH-1:0]         wr_data,
   output logic                     full,
   output logic                     almost_full,
   input  logic                     rd_en,
   output logic [WIDTH-1:0]         rd_data,
   output logic                     rd_valid,
   output logic                     empty,
   output logic                     almost_empty,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     overflow,
   output logic                     underflow
`ifdef SYNC_FIFO_WATERMARK_EN
   ,
   output logic [$clog2(DEPTH):0]   max_level
`endif
);

   localparam int ADDR_WIDTH = $clog2(DEPTH);
   localparam logic [ADDR_WIDTH:0] c_DEPTH  = (ADDR_WIDTH+1)'(DEPTH);
   localparam logic [ADDR_WIDTH:0] c_AFULL  = (ADDR_WIDTH+1)'(AFULL_THRESH);
   localparam logic [ADDR_WIDTH:0] c_AEMPTY = (ADDR_WIDTH+1)'(AEMPTY_THRESH);
   localparam logic [ADDR_WIDTH:0] c_ONE    = (ADDR_WIDTH+1)'(1);

   generate
      if ((DEPTH < 4) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
         $fatal(1, "sync_fifo: DEPTH must be a power of 2 and >= 4");
      end
      if ((AFULL_THRESH < 1) || (AFULL_THRESH > DEPTH)) begin : g_bad_afull
         $fatal(1, "sync_fifo: AFULL_THRESH out of range");
      end
      if ((AEMPTY_THRESH < 0) || (AEMPTY_THRESH > DEPTH - 1)) begin : g_bad_aempty
         $fatal(1, "sync_fifo: AEMPTY_THRESH out of range");
      end
      if ((FWFT != 0) && (FWFT != 1)) begin : g_bad_fwft
         $fatal(1, "sync_fifo: FWFT must be 0 or 1");
      end
   endgenerate

   logic [WIDTH-1:0]    r_mem [DEPTH];
   logic [ADDR_WIDTH:0] r_wr_ptr;
   logic [ADDR_WIDTH:0] r_rd_ptr;
   logic [ADDR_WIDTH:0] r_count;
   logic                r_full;
   logic                r_empty;
   logic                r_afull;
   logic                r_aempty;
   logic [WIDTH-1:0]    r_rd_data;
   logic                r_rd_valid;
   logic                r_overflow;
   logic                r_underflow;

   logic                w_wr_acc;
   logic                w_rd_acc;
   logic                w_mem_rd;
   logic                w_rd_valid_next;
   logic                w_empty_next;
   logic [ADDR_WIDTH:0] w_count_next;

   assign w_wr_acc = wr_en & ~r_full  & ~flush;
   assign w_rd_acc = rd_en & ~r_empty & ~flush;

   always_comb begin
      w_count_next = r_count;
      if (flush)
         w_count_next = '0;
      else if (w_wr_acc && !w_rd_acc)
         w_count_next = r_count + c_ONE;
      else if (!w_wr_acc && w_rd_acc)
         w_count_next = r_count - c_ONE;
   end

   generate
      if (FWFT == 1) begin : g_fwft
         // r_rd_valid doubles as the prefetch-stage occupancy; refill it
         // whenever it is empty or being popped and memory holds a word.
         assign w_mem_rd        = ~flush & (r_wr_ptr != r_rd_ptr) & (~r_rd_valid | w_rd_acc);
         assign w_rd_valid_next = ~flush & (w_mem_rd | (r_rd_valid & ~w_rd_acc));
         assign w_empty_next    = ~w_rd_valid_next;
      end else begin : g_std
         assign w_mem_rd        = w_rd_acc;
         assign w_rd_valid_next = w_rd_acc;
         assign w_empty_next    = (w_count_next == '0);
      end
   endgenerate

   always_ff @(posedge i_clk) begin
      if (w_wr_acc)
         r_mem[r_wr_ptr[ADDR_WIDTH-1:0]] <= wr_data;
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_wr_ptr    <= '0;
         r_rd_ptr    <= '0;
         r_count     <= '0;
         r_full      <= 1'b0;
         r_empty     <= 1'b1;
         r_afull     <= 1'b0;
         r_aempty    <= 1'b1;
         r_rd_data   <= '0;
         r_rd_valid  <= 1'b0;
         r_overflow  <= 1'b0;
         r_underflow <= 1'b0;
      end else begin
         if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
         end else begin
            if (w_wr_acc)
               r_wr_ptr <= r_wr_ptr + c_ONE;
            if (w_mem_rd)
               r_rd_ptr <= r_rd_ptr + c_ONE;
         end
         if (w_mem_rd)
            r_rd_data <= r_mem[r_rd_ptr[ADDR_WIDTH-1:0]];
         r_rd_valid  <= w_rd_valid_next;
         r_count     <= w_count_next;
         r_full      <= (w_count_next == c_DEPTH);
         r_empty     <= w_empty_next;
         r_afull     <= (w_count_next >= c_AFULL);
         r_aempty    <= (w_count_next <= c_AEMPTY);
         r_overflow  <= ~flush & (r_overflow  | (wr_en & r_full));
         r_underflow <= ~flush & (r_underflow | (rd_en & r_empty));
      end
   end

`ifdef SYNC_FIFO_WATERMARK_EN
   logic [ADDR_WIDTH:0] r_max_level;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n)
         r_max_level <= '0;
      else if (flush)
         r_max_level <= '0;
      else if (r_count > r_max_level)
         r_max_level <= r_count;
   end

   assign max_level = r_max_level;
`endif

   assign full         = r_full;
   assign almost_full  = r_afull;
   assign empty        = r_empty;
   assign almost_empty = r_aempty;
   assign count        = r_count;
   assign rd_data      = r_rd_data;
   assign rd_valid     = r_rd_valid;
   assign overflow     = r_overflow;
   assign underflow    = r_underflow;

endmodule
`default_nettype wire

// File: tb/tb_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tb_sync_fifo
// Brief    : Scoreboard bench for sync_fifo, standard and FWFT instances.
// Revision : 1.0
// ============================================================================
module tb_sync_fifo;
   localparam int D = 16;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   logic       flush_a, wr_en_a, rd_en_a;
   logic [7:0] wr_data_a, rd_data_a;
   logic       full_a, afull_a, rd_valid_a, empty_a, aempty_a, ovf_a, udf_a;
   logic [4:0] count_a;

   logic       flush_b, wr_en_b, rd_en_b;
   logic [7:0] wr_data_b, rd_data_b;
   logic       full_b, afull_b, rd_valid_b, empty_b, aempty_b, ovf_b, udf_b;
   logic [4:0] count_b;
`ifdef SYNC_FIFO_WATERMARK_EN
   logic [4:0] max_a, max_b;
`endif

   sync_fifo #(.WIDTH(8), .DEPTH(D), .FWFT(0)) u_std (
      .i_clk(clk), .i_rst_n(rst_n), .flush(flush_a),
      .wr_en(wr_en_a), .wr_data(wr_data_a), .full(full_a), .almost_full(afull_a),
      .rd_en(rd_en_a), .rd_data(rd_data_a), .rd_valid(rd_valid_a), .empty(empty_a),
      .almost_empty(aempty_a), .count(count_a), .overflow(ovf_a), .underflow(udf_a)
`ifdef SYNC_FIFO_WATERMARK_EN
      , .max_level(max_a)
`endif
   );

   sync_fifo #(.WIDTH(8), .DEPTH(D), .FWFT(1)) u_fwft (
      .i_clk(clk), .i_rst_n(rst_n), .flush(flush_b),
      .wr_en(wr_en_b), .wr_data(wr_data_b), .full(full_b), .almost_full(afull_b),
      .rd_en(rd_en_b), .rd_data(rd_data_b), .rd_valid(rd_valid_b), .empty(empty_b),
      .almost_empty(aempty_b), .count(count_b), .overflow(ovf_b), .underflow(udf_b)
`ifdef SYNC_FIFO_WATERMARK_EN
      , .max_level(max_b)
`endif
   );

   int checks = 0;
   int failures = 0;

   logic [7:0] q_a[$];
   logic [7:0] q_b[$];
   int mcnt = 0, mpeak = 0, exp_pops_a = 0, got_pops_a = 0, got_pops_b = 0;
   bit movf = 0, mudf = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Pop and compare whenever a DUT presents a word
   always @(negedge clk) begin
      if (rst_n && rd_valid_a) begin
         got_pops_a++;
         if (q_a.size() == 0) chk("std_unexpected_word", 32'(rd_data_a), 32'h1FF);
         else chk("std_rd_data", 32'(rd_data_a), 32'(q_a.pop_front()));
      end
      if (rst_n && rd_valid_b && rd_en_b) begin
         got_pops_b++;
         if (q_b.size() == 0) chk("fwft_unexpected_word", 32'(rd_data_b), 32'h1FF);
         else chk("fwft_rd_data", 32'(rd_data_b), 32'(q_b.pop_front()));
      end
   end

   // One standard-instance cycle with the expected state checked after the edge
   task automatic cyc_a(input bit w, input logic [7:0] d, input bit r, input bit f);
      bit wacc, racc;
      wr_en_a = w; wr_data_a = d; rd_en_a = r; flush_a = f;
      wacc = f ? 1'b0 : (w && mcnt != D);
      racc = f ? 1'b0 : (r && mcnt != 0);
      if (!f) begin
         if (w && mcnt == D) movf = 1;
         if (r && mcnt == 0) mudf = 1;
      end
      if (wacc) q_a.push_back(d);
      if (racc) exp_pops_a++;
      mcnt = mcnt + int'(wacc) - int'(racc);
      if (f) begin
         mcnt = 0; movf = 0; mudf = 0; mpeak = 0;
         q_a.delete();
      end
      @(posedge clk); #1;
      wr_en_a = 0; rd_en_a = 0; flush_a = 0;
      if (mcnt > mpeak) mpeak = mcnt;
      chk("std_count", 32'(count_a), 32'(mcnt));
      chk("std_full", 32'(full_a), 32'(mcnt == D));
      chk("std_empty", 32'(empty_a), 32'(mcnt == 0));
      chk("std_almost_full", 32'(afull_a), 32'(mcnt >= D - 2));
      chk("std_almost_empty", 32'(aempty_a), 32'(mcnt <= 2));
      chk("std_overflow", 32'(ovf_a), 32'(movf));
      chk("std_underflow", 32'(udf_a), 32'(mudf));
      chk("std_rd_valid", 32'(rd_valid_a), 32'(racc));
   endtask

   task automatic tick_b;
      @(posedge clk); #1;
   endtask

   initial begin
      rst_n = 0;
      flush_a = 0; wr_en_a = 0; rd_en_a = 0; wr_data_a = 0;
      flush_b = 0; wr_en_b = 0; rd_en_b = 0; wr_data_b = 0;
      #12;
      chk("rst_empty", 32'(empty_a), 1);
      chk("rst_almost_empty", 32'(aempty_a), 1);
      chk("rst_full", 32'(full_a), 0);
      chk("rst_count", 32'(count_a), 0);
      chk("rst_ovf_udf", 32'({ovf_a, udf_a}), 0);
      chk("rst_rd_data", 32'(rd_data_a), 0);
      chk("rst_rd_valid", 32'(rd_valid_a), 0);
      chk("rst_fwft_empty", 32'(empty_b), 1);
      chk("rst_fwft_rd_data", 32'(rd_data_b), 0);
      #10 rst_n = 1;
      @(posedge clk); #1;

      // Fill, overflow, drain
      for (int i = 0; i < D; i++) begin
         cyc_a(1, 8'(i), 0, 0);
         if (i == 12) chk("afull_below_thresh", 32'(afull_a), 0);
         if (i == 13) chk("afull_at_14", 32'(afull_a), 1);
      end
      chk("fill_full", 32'(full_a), 1);
      chk("fill_count", 32'(count_a), 16);
      cyc_a(1, 8'hEE, 0, 0);
      chk("write17_overflow", 32'(ovf_a), 1);
      chk("write17_count", 32'(count_a), 16);
      for (int i = 0; i < D; i++) cyc_a(0, 0, 1, 0);
      cyc_a(0, 0, 0, 0);
      chk("drain_pops", 32'(got_pops_a), 32'(exp_pops_a));
      chk("drain_empty", 32'(empty_a), 1);

      // Simultaneous write and read at the boundaries
      cyc_a(0, 0, 0, 1);
      for (int i = 0; i < D; i++) cyc_a(1, 8'(8'h20 + i), 0, 0);
      cyc_a(1, 8'h55, 1, 0);
      chk("simul_full_count", 32'(count_a), 15);
      chk("simul_full_overflow", 32'(ovf_a), 1);
      for (int i = 0; i < 15; i++) cyc_a(0, 0, 1, 0);
      cyc_a(0, 0, 0, 0);
      cyc_a(1, 8'h66, 1, 0);
      chk("simul_empty_count", 32'(count_a), 1);
      chk("simul_empty_underflow", 32'(udf_a), 1);
      for (int i = 0; i < 4; i++) cyc_a(1, 8'(8'h70 + i), 0, 0);
      cyc_a(1, 8'h77, 1, 0);
      chk("simul_mid_count", 32'(count_a), 5);
      for (int i = 0; i < 5; i++) cyc_a(0, 0, 1, 0);
      cyc_a(0, 0, 0, 0);
      chk("simul_pops", 32'(got_pops_a), 32'(exp_pops_a));

      // Flush at count 9 overrides write and read
      for (int i = 0; i < 9; i++) cyc_a(1, 8'(8'h80 + i), 0, 0);
      chk("preflush_count", 32'(count_a), 9);
      cyc_a(1, 8'h99, 1, 1);
      chk("flush_count", 32'(count_a), 0);
      chk("flush_empty", 32'(empty_a), 1);
      chk("flush_flags", 32'({ovf_a, udf_a}), 0);
`ifdef SYNC_FIFO_WATERMARK_EN
      chk("flush_max_level", 32'(max_a), 0);
`endif
      cyc_a(1, 8'h42, 0, 0);
      cyc_a(0, 0, 1, 0);
      cyc_a(0, 0, 0, 0);
      chk("postflush_pops", 32'(got_pops_a), 32'(exp_pops_a));

      // Random traffic across several pointer wraps
      for (int i = 0; i < 6 * D; i++)
         cyc_a($urandom_range(0, 99) < 55, 8'($urandom_range(0, 255)), $urandom_range(0, 99) < 50, 0);
      for (int i = 0; i < 2 * D && mcnt > 0; i++) cyc_a(0, 0, 1, 0);
      cyc_a(0, 0, 0, 0);
      cyc_a(0, 0, 0, 0);
      chk("random_pops", 32'(got_pops_a), 32'(exp_pops_a));
      chk("random_queue_empty", 32'(q_a.size()), 0);
`ifdef SYNC_FIFO_WATERMARK_EN
      chk("random_max_level", 32'(max_a), 32'(mpeak));
`endif

      // FWFT latency and back-to-back pops
      wr_en_b = 1; wr_data_b = 8'hA5; q_b.push_back(8'hA5);
      tick_b();
      wr_en_b = 0;
      chk("fwft_lat_empty1", 32'(empty_b), 1);
      chk("fwft_lat_count1", 32'(count_b), 1);
      tick_b();
      chk("fwft_lat_empty2", 32'(empty_b), 0);
      chk("fwft_lat_data", 32'(rd_data_b), 32'hA5);
      chk("fwft_lat_valid", 32'(rd_valid_b), 1);
      rd_en_b = 1;
      tick_b();
      rd_en_b = 0;
      chk("fwft_pop_empty", 32'(empty_b), 1);
      chk("fwft_pop_count", 32'(count_b), 0);
      for (int i = 1; i <= 4; i++) begin
         wr_en_b = 1; wr_data_b = 8'(i); q_b.push_back(8'(i));
         tick_b();
      end
      wr_en_b = 0;
      tick_b();
      tick_b();
      chk("fwft_b2b_count", 32'(count_b), 4);
      chk("fwft_b2b_head", 32'(rd_data_b), 1);
      rd_en_b = 1;
      for (int i = 0; i < 4; i++) begin
         chk("fwft_no_bubble", 32'(empty_b), 0);
         tick_b();
      end
      rd_en_b = 0;
      chk("fwft_b2b_empty", 32'(empty_b), 1);
      chk("fwft_b2b_valid", 32'(rd_valid_b), 0);
      chk("fwft_pops", 32'(got_pops_b), 5);
      chk("fwft_no_underflow", 32'(udf_b), 0);
      rd_en_b = 1;
      tick_b();
      rd_en_b = 0;
      chk("fwft_underflow", 32'(udf_b), 1);

      // Asynchronous reset while a read response is pending
      cyc_a(1, 8'h11, 0, 0);
      rd_en_a = 1;
      @(posedge clk); #1;
      rd_en_a = 0;
      rst_n = 0;
      #1;
      chk("midrst_rd_valid", 32'(rd_valid_a), 0);
      chk("midrst_count", 32'(count_a), 0);
      chk("midrst_empty", 32'(empty_a), 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
